// File: rtl/axi4l_reg_bridge_if.sv
// AXI4-Lite slave-side channel bundle for axi4l_reg_bridge.
// The master modport drives requests; the slave modport drives readies and responses.
interface axi4l_reg_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4l_reg_bridge.sv
// AXI4-Lite slave to req/ack register-bus bridge, one transaction in flight, write wins over read.
// Optional ack timeout enabled by defining AXI4L_REGS_TIMEOUT_EN.
module axi4l_reg_bridge #(
  parameter int                        AXI_ADDR_WIDTH   = 32,
  parameter int                        AXI_DATA_WIDTH   = 32,
  parameter int                        REG_ADDR_WIDTH   = 16,
  parameter int                        REG_DATA_WIDTH   = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_OFFSET      = 32'h8000_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_OFFSET_MASK = 32'h0000_FFFF,
  parameter int                        TIMEOUT_CYCLES   = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  axi4l_reg_bridge_if.slave           s_axi,
  output logic [REG_ADDR_WIDTH-1:0]   reg_addr,
  output logic [REG_DATA_WIDTH-1:0]   reg_wdata,
  output logic                        reg_wren,
  output logic [REG_DATA_WIDTH/8-1:0] reg_be,
  output logic                        reg_req,
  input  logic [REG_DATA_WIDTH-1:0]   reg_rdata,
  input  logic                        reg_ack,
  input  logic                        reg_err
);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, WR_COLLECT, REG_ACCESS, WR_RESP, RD_RESP} state_e;

  function automatic logic in_window(input logic [AXI_ADDR_WIDTH-1:0] a);
    return (a & ~BASE_OFFSET_MASK) == BASE_OFFSET;
  endfunction

  function automatic logic [REG_ADDR_WIDTH-1:0] map_addr(input logic [AXI_ADDR_WIDTH-1:0] a);
    return REG_ADDR_WIDTH'(a & BASE_OFFSET_MASK) & ~REG_ADDR_WIDTH'(3);
  endfunction

  state_e                      state_q, state_d;
  logic                        awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic                        aw_done_q, aw_done_d, w_done_q, w_done_d, hit_q, hit_d;
  logic [REG_ADDR_WIDTH-1:0]   reg_addr_q, reg_addr_d;
  logic [REG_DATA_WIDTH-1:0]   reg_wdata_q, reg_wdata_d, rdata_q, rdata_d;
  logic [REG_DATA_WIDTH/8-1:0] reg_be_q, reg_be_d;
  logic                        reg_wren_q, reg_wren_d, reg_req_q, reg_req_d;
  logic                        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]                  resp_q, resp_d;
  logic                        aw_hs, w_hs, ar_hs, timeout;
  logic [AXI_DATA_WIDTH-1:0]   wdata_in;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb_in;

  assign wdata_in = s_axi.wdata;
  assign wstrb_in = s_axi.wstrb;
  assign aw_hs    = s_axi.awvalid & awready_q;
  assign w_hs     = s_axi.wvalid & wready_q;
  assign ar_hs    = s_axi.arvalid & arready_q;

`ifdef AXI4L_REGS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Counts cycles of the current request; zero whenever reg_req is low.
  always_comb begin
    tmo_d = reg_req_q ? tmo_q + TMO_W'(1) : '0;
  end
  assign timeout = reg_req_q && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  // No timeout: the bridge waits for ack/err indefinitely.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d     = state_q;
    awready_d   = 1'b0;
    wready_d    = 1'b0;
    arready_d   = 1'b0;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    hit_d       = hit_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_be_d    = reg_be_q;
    reg_wren_d  = reg_wren_q;
    reg_req_d   = reg_req_q;
    bvalid_d    = bvalid_q;
    rvalid_d    = rvalid_q;
    resp_d      = resp_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        // An already-raised arready commits the read even if a write shows up now.
        if (ar_hs) begin
          reg_addr_d = map_addr(s_axi.araddr);
          reg_wren_d = 1'b0;
          reg_be_d   = '1;
          if (in_window(s_axi.araddr)) begin
            reg_req_d = 1'b1;
            state_d   = REG_ACCESS;
          end else begin
            resp_d   = RESP_DECERR;
            rdata_d  = '0;
            rvalid_d = 1'b1;
            state_d  = RD_RESP;
          end
        end else if (s_axi.awvalid || s_axi.wvalid) begin
          awready_d  = s_axi.awvalid;
          wready_d   = s_axi.wvalid;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          reg_wren_d = 1'b1;
          state_d    = WR_COLLECT;
        end else if (s_axi.arvalid) begin
          arready_d = 1'b1;
        end
      end
      WR_COLLECT: begin
        if (aw_hs) begin
          aw_done_d  = 1'b1;
          reg_addr_d = map_addr(s_axi.awaddr);
          hit_d      = in_window(s_axi.awaddr);
        end else if (!aw_done_q && s_axi.awvalid) begin
          awready_d = 1'b1;
        end
        if (w_hs) begin
          w_done_d    = 1'b1;
          reg_wdata_d = wdata_in;
          reg_be_d    = wstrb_in;
        end else if (!w_done_q && s_axi.wvalid) begin
          wready_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          if (hit_d) begin
            reg_req_d = 1'b1;
            state_d   = REG_ACCESS;
          end else begin
            resp_d   = RESP_DECERR;
            bvalid_d = 1'b1;
            state_d  = WR_RESP;
          end
        end
      end
      REG_ACCESS: begin
        if (reg_ack || reg_err || timeout) begin
          reg_req_d = 1'b0;
          if (reg_err || !reg_ack) begin
            resp_d  = RESP_SLVERR;
            rdata_d = '0;
          end else begin
            resp_d = RESP_OKAY;
            if (!reg_wren_q) rdata_d = reg_rdata;
          end
          if (reg_wren_q) begin
            bvalid_d = 1'b1;
            state_d  = WR_RESP;
          end else begin
            rvalid_d = 1'b1;
            state_d  = RD_RESP;
          end
        end
      end
      WR_RESP: begin
        if (s_axi.bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RD_RESP: begin
        if (s_axi.rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      arready_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      hit_q       <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_be_q    <= '0;
      reg_wren_q  <= 1'b0;
      reg_req_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      resp_q      <= 2'b00;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      arready_q   <= arready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      hit_q       <= hit_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_be_q    <= reg_be_d;
      reg_wren_q  <= reg_wren_d;
      reg_req_q   <= reg_req_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
      resp_q      <= resp_d;
      rdata_q     <= rdata_d;
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.arready = arready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = resp_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = resp_q;
  assign s_axi.rdata   = rdata_q;
  assign reg_addr      = reg_addr_q;
  assign reg_wdata     = reg_wdata_q;
  assign reg_be        = reg_be_q;
  assign reg_wren      = reg_wren_q;
  assign reg_req       = reg_req_q;
endmodule

// File: tb/tb_axi4l_reg_bridge.sv
// Scoreboard bench for axi4l_reg_bridge against a 4-register downstream block
// (write mask 4'b1011, reg2 reads 0x0000FFFF, offsets beyond 0xC answer with reg_err).
`timescale 1ns/1ps
module tb_axi4l_reg_bridge;
  localparam int BUDGET = 200;
  localparam logic [3:0] WMASK = 4'b1011;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi4l_reg_bridge_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  logic [15:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wren;
  logic [3:0]  reg_be;
  logic        reg_req;
  logic [31:0] reg_rdata = 32'h0;
  logic        reg_ack = 1'b0;
  logic        reg_err = 1'b0;

  axi4l_reg_bridge dut (
    .clk(clk), .rstn(rstn), .s_axi(axi),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wren(reg_wren), .reg_be(reg_be),
    .reg_req(reg_req), .reg_rdata(reg_rdata), .reg_ack(reg_ack), .reg_err(reg_err)
  );

  // Downstream register block; answers at the negedge so the bridge sees it at the next posedge.
  logic [31:0] regs [4];
  int  ack_dly = 0, wait_cnt = 0, req_edges = 0, req_cycles = 0;
  bit  no_ack = 1'b0, answered = 1'b0;
  logic req_prev = 1'b0;

  always @(negedge clk) begin
    int idx;
    reg_ack   = 1'b0;
    reg_err   = 1'b0;
    reg_rdata = 32'hBAD0_BAD0;
    if (reg_req && !req_prev) req_edges++;
    if (reg_req) req_cycles++;
    req_prev = reg_req;
    if (!reg_req) begin
      wait_cnt = 0;
      answered = 1'b0;
    end else if (!answered && !no_ack) begin
      if (wait_cnt < ack_dly) wait_cnt++;
      else begin
        answered = 1'b1;
        idx = int'(reg_addr[15:2]);
        if (idx > 3) reg_err = 1'b1;
        else begin
          reg_ack = 1'b1;
          if (reg_wren) begin
            if (WMASK[idx])
              for (int b = 0; b < 4; b++)
                if (reg_be[b]) regs[idx][8*b +: 8] = reg_wdata[8*b +: 8];
          end else begin
            reg_rdata = (idx == 2) ? 32'h0000_FFFF : regs[idx];
          end
        end
      end
    end
  end

  int n_checks = 0, n_errors = 0;
  logic [1:0]  exp_b_q [$];
  logic [33:0] exp_r_q [$];
  time t_b, t_r;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_aw(input logic [31:0] a, input int dly);
    int n = 0;
    repeat (dly) @(negedge clk);
    axi.awaddr = a; axi.awvalid = 1'b1;
    while (!axi.awready && n < BUDGET) begin @(negedge clk); n++; end
    check_eq("aw_accept", n < BUDGET, 1);
    @(negedge clk);
    axi.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int n = 0;
    repeat (dly) @(negedge clk);
    axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1;
    while (!axi.wready && n < BUDGET) begin @(negedge clk); n++; end
    check_eq("w_accept", n < BUDGET, 1);
    @(negedge clk);
    axi.wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    int n = 0;
    axi.araddr = a; axi.arvalid = 1'b1;
    while (!axi.arready && n < BUDGET) begin @(negedge clk); n++; end
    check_eq("ar_accept", n < BUDGET, 1);
    @(negedge clk);
    axi.arvalid = 1'b0;
  endtask

  task automatic recv_b(input int hold);
    int n = 0;
    logic [1:0] r0;
    while (!axi.bvalid && n < BUDGET) begin @(negedge clk); n++; end
    check_eq("b_seen", axi.bvalid, 1);
    if (axi.bvalid) begin
      t_b = $time;
      r0 = axi.bresp;
      repeat (hold) begin
        @(negedge clk);
        check_eq("b_hold_valid", axi.bvalid, 1);
        check_eq("b_hold_resp", axi.bresp, r0);
      end
      check_eq("sb_b_pending", exp_b_q.size(), 1);
      if (exp_b_q.size() > 0) check_eq("bresp", axi.bresp, exp_b_q.pop_front());
      axi.bready = 1'b1;
      @(negedge clk);
      axi.bready = 1'b0;
      check_eq("b_drop", axi.bvalid, 0);
    end
  endtask

  task automatic recv_r(input int hold);
    int n = 0;
    logic [33:0] r0;
    while (!axi.rvalid && n < BUDGET) begin @(negedge clk); n++; end
    check_eq("r_seen", axi.rvalid, 1);
    if (axi.rvalid) begin
      t_r = $time;
      r0 = {axi.rresp, axi.rdata};
      repeat (hold) begin
        @(negedge clk);
        check_eq("r_hold_valid", axi.rvalid, 1);
        check_eq("r_hold_resp_data", {axi.rresp, axi.rdata}, r0);
      end
      check_eq("sb_r_pending", exp_r_q.size(), 1);
      if (exp_r_q.size() > 0) check_eq("rresp_rdata", {axi.rresp, axi.rdata}, exp_r_q.pop_front());
      axi.rready = 1'b1;
      @(negedge clk);
      axi.rready = 1'b0;
      check_eq("r_drop", axi.rvalid, 0);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int hold, input logic [1:0] er);
    exp_b_q.push_back(er);
    fork
      send_aw(a, aw_dly);
      send_w(d, s, w_dly);
    join
    recv_b(hold);
  endtask

  task automatic axi_read(input logic [31:0] a, input int hold, input logic [1:0] er,
                          input logic [31:0] ed, input bit chk_lat);
    exp_r_q.push_back({er, ed});
    send_ar(a);
    if (chk_lat) begin
      check_eq("rd_req_next_cycle", reg_req, 1);
      @(negedge clk);
      check_eq("rd_rvalid_after_ack", axi.rvalid, 1);
    end
    recv_r(hold);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r0, n;
    bit saw;
    for (int i = 0; i < 4; i++) regs[i] = 32'h0;
    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_readies", {axi.awready, axi.wready, axi.arready}, 0);
    check_eq("rst_valids", {axi.bvalid, axi.rvalid}, 0);
    check_eq("rst_resp", {axi.bresp, axi.rresp, axi.rdata}, 0);
    check_eq("rst_regbus", {reg_req, reg_wren, reg_be, reg_addr, reg_wdata}, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Reads after reset, including the out-of-range register
    axi_read(32'h8000_0000, 0, 2'b00, 32'h0, 1'b1);
    axi_read(32'h8000_0004, 0, 2'b00, 32'h0, 1'b0);
    axi_read(32'h8000_0008, 0, 2'b00, 32'h0000_FFFF, 1'b0);
    axi_read(32'h8000_000C, 0, 2'b00, 32'h0, 1'b0);
    axi_read(32'h8000_0010, 0, 2'b10, 32'h0, 1'b0);

    // Full and partial-strobe writes
    axi_write(32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00);
    axi_read(32'h8000_0000, 0, 2'b00, 32'hDEAD_BEEF, 1'b0);
    axi_write(32'h8000_0000, 32'h0000_00AA, 4'h1, 0, 0, 0, 2'b00);
    axi_read(32'h8000_0000, 0, 2'b00, 32'hDEAD_BEAA, 1'b0);

    // Window misses
    r0 = req_edges;
    axi_write(32'h9000_0000, 32'h1234_5678, 4'hF, 0, 0, 0, 2'b11);
    axi_read(32'h9000_0000, 0, 2'b11, 32'h0, 1'b0);
    check_eq("decerr_no_req", req_edges - r0, 0);

    // AW before W, then W before AW
    r0 = req_edges;
    axi_write(32'h8000_0004, 32'h1234_5678, 4'hF, 0, 3, 0, 2'b00);
    check_eq("aw_first_one_req", req_edges - r0, 1);
    axi_read(32'h8000_0004, 0, 2'b00, 32'h1234_5678, 1'b0);
    r0 = req_edges;
    axi_write(32'h8000_000C, 32'hCAFE_F00D, 4'hF, 3, 0, 0, 2'b00);
    check_eq("w_first_one_req", req_edges - r0, 1);
    axi_read(32'h8000_000C, 0, 2'b00, 32'hCAFE_F00D, 1'b0);

    // Simultaneous write and read: write must complete first
    fork
      axi_write(32'h8000_0000, 32'h1111_1111, 4'hF, 0, 0, 0, 2'b00);
      axi_read(32'h8000_0004, 0, 2'b00, 32'h1234_5678, 1'b0);
    join
    check_eq("wr_before_rd", t_b < t_r, 1);
    axi_read(32'h8000_0000, 0, 2'b00, 32'h1111_1111, 1'b0);

    // Slow ack and stalled responses
    ack_dly = 2;
    axi_write(32'h8000_0004, 32'hA5A5_A5A5, 4'hF, 0, 0, 5, 2'b00);
    axi_read(32'h8000_0004, 5, 2'b00, 32'hA5A5_A5A5, 1'b0);
    axi_write(32'h8000_0008, 32'h0000_1234, 4'hF, 0, 0, 0, 2'b00);
    axi_read(32'h8000_0008, 0, 2'b00, 32'h0000_FFFF, 1'b0);
    axi_write(32'h8000_0010, 32'h0000_0001, 4'hF, 1, 0, 3, 2'b10);
    ack_dly = 0;

    // Reset while a request is outstanding
    no_ack = 1'b1;
    send_ar(32'h8000_0004);
    n = 0;
    while (!reg_req && n < 20) begin @(negedge clk); n++; end
    check_eq("req_before_abort", reg_req, 1);
    rstn = 1'b0;
    #1;
    check_eq("abort_req_cleared", reg_req, 0);
    check_eq("abort_valids_cleared", {axi.bvalid, axi.rvalid, axi.arready}, 0);
    repeat (3) @(negedge clk);
    no_ack = 1'b0;
    rstn = 1'b1;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (axi.rvalid || axi.bvalid) saw = 1'b1;
    end
    check_eq("abort_no_response", saw, 0);
    axi_read(32'h8000_0000, 0, 2'b00, 32'h1111_1111, 1'b0);

`ifdef AXI4L_REGS_TIMEOUT_EN
    no_ack = 1'b1;
    r0 = req_cycles;
    axi_read(32'h8000_0000, 0, 2'b10, 32'h0, 1'b0);
    check_eq("timeout_req_cycles", req_cycles - r0, 16);
    no_ack = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
